// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding and load-use stall control for the rv32 pipeline.
// For every decode source operand the youngest matching writer stage is selected;
// its result is registered into fwd_hit/fwd_data for execute one cycle later.
// A load whose data is not yet on stg_data holds decode via a small stall FSM.
// Optional statistics counters are built only when FWD_STATS_EN is defined.
module fwd_hazard_ctrl #(
   parameter int XLEN     = 32,
   parameter int NSRC     = 2,
   parameter int NSTG     = 3,
   parameter int LOAD_STG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   de_valid,
   input  logic [NSRC*5-1:0]      de_rs,
   input  logic [NSRC-1:0]        de_rs_used,
   input  logic [NSTG-1:0]        stg_valid,
   input  logic [NSTG-1:0]        stg_wen,
   input  logic [NSTG-1:0]        stg_is_load,
   input  logic [NSTG*5-1:0]      stg_rd,
   input  logic [NSTG*XLEN-1:0]   stg_data,
   output logic                   stall,
   output logic [NSRC-1:0]        fwd_hit,
   output logic [NSRC*XLEN-1:0]   fwd_data,
   output logic [31:0]            stat_stall_cycles,
   output logic [31:0]            stat_fwd_events
);

   localparam int CW = $clog2(NSTG + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NSRC-1:0]      fwd_hit_q, fwd_hit_d;
   logic [NSRC*XLEN-1:0] fwd_data_q, fwd_data_d;

   logic [NSRC-1:0]      win_found_s;
   logic [NSRC-1:0]      win_ready_s;
   logic [NSRC*XLEN-1:0] win_data_s;
   logic [NSRC*CW-1:0]   win_wait_s;
   logic [CW-1:0]        max_wait_s;
   logic                 not_ready_s;
   logic                 stall_s;

   // Pick the youngest matching producer per operand; scanning old-to-young lets younger overwrite.
   always_comb begin
      win_found_s = '0;
      win_ready_s = '0;
      win_data_s  = '0;
      win_wait_s  = '0;
      for (int s = 0; s < NSRC; s++) begin
         for (int k = NSTG - 1; k >= 0; k--) begin
            if (de_valid && de_rs_used[s] && stg_valid[k] && stg_wen[k] &&
                (stg_rd[5*k +: 5] == de_rs[5*s +: 5]) && (de_rs[5*s +: 5] != 5'd0)) begin
               win_found_s[s]              = 1'b1;
               win_data_s[XLEN*s +: XLEN]  = stg_data[XLEN*k +: XLEN];
               if (stg_is_load[k] && (k < LOAD_STG)) begin
                  win_ready_s[s]          = 1'b0;
                  win_wait_s[CW*s +: CW]  = CW'(LOAD_STG - k);
               end else begin
                  win_ready_s[s]          = 1'b1;
                  win_wait_s[CW*s +: CW]  = '0;
               end
            end else begin
               // no match here: keep whatever an older stage selected
               win_found_s[s] = win_found_s[s];
            end
         end
      end
   end

   // Largest wait over all operands decides how long decode is held.
   always_comb begin
      max_wait_s = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (win_wait_s[CW*s +: CW] > max_wait_s) begin
            max_wait_s = win_wait_s[CW*s +: CW];
         end else begin
            max_wait_s = max_wait_s;
         end
      end
      not_ready_s = (max_wait_s != '0);
   end

   // Stall is combinational so decode is held in the detection cycle; rst and flush mask it at once.
   always_comb begin
      stall_s = !rst && !flush && ((state_q == ST_STALL) || not_ready_s);
   end

   // Stall FSM next state: first stall cycle happens in IDLE, remaining ones are counted in STALL.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (not_ready_s) begin
                  cnt_d   = max_wait_s - CW'(1);
                  state_d = (max_wait_s > CW'(1)) ? ST_STALL : ST_IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            ST_STALL: begin
               if (cnt_q <= CW'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q - CW'(1);
                  state_d = ST_STALL;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Forwarding capture: execute gets a bubble (all zero) whenever decode is held or flushed.
   always_comb begin
      fwd_hit_d  = '0;
      fwd_data_d = '0;
      if (flush || stall_s) begin
         fwd_hit_d  = '0;
         fwd_data_d = '0;
      end else begin
         fwd_hit_d  = win_found_s & win_ready_s;
         fwd_data_d = win_data_s;
      end
   end

   // State and forwarding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         fwd_hit_q  <= '0;
         fwd_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   assign stall    = stall_s;
   assign fwd_hit  = fwd_hit_q;
   assign fwd_data = fwd_data_q;

`ifdef FWD_STATS_EN
   logic [31:0] stat_stall_q;
   logic [31:0] stat_fwd_q;
   logic [32:0] fwd_sum_s;

   // Saturating sum for the forwarding-event counter.
   always_comb begin
      fwd_sum_s = {1'b0, stat_fwd_q} + 33'($countones(fwd_hit_d));
   end

   // Statistics counters: saturate at all-ones, cleared only by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_stall_q <= 32'd0;
         stat_fwd_q   <= 32'd0;
      end else begin
         if (stall_s && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end else begin
            stat_stall_q <= stat_stall_q;
         end
         if (fwd_sum_s[32]) begin
            stat_fwd_q <= 32'hFFFF_FFFF;
         end else begin
            stat_fwd_q <= fwd_sum_s[31:0];
         end
      end
   end

   assign stat_stall_cycles = stat_stall_q;
   assign stat_fwd_events   = stat_fwd_q;
`else
   assign stat_stall_cycles = 32'd0;
   assign stat_fwd_events   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl (NSTG=3, LOAD_STG=2, NSRC=2, XLEN=32).
module tb_fwd_hazard_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         de_valid;
   logic [9:0]   de_rs;
   logic [1:0]   de_rs_used;
   logic [2:0]   stg_valid;
   logic [2:0]   stg_wen;
   logic [2:0]   stg_is_load;
   logic [14:0]  stg_rd;
   logic [95:0]  stg_data;
   logic         stall;
   logic [1:0]   fwd_hit;
   logic [63:0]  fwd_data;
   logic [31:0]  stat_stall_cycles;
   logic [31:0]  stat_fwd_events;

   fwd_hazard_ctrl #(.XLEN(32), .NSRC(2), .NSTG(3), .LOAD_STG(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .de_valid(de_valid), .de_rs(de_rs),
      .de_rs_used(de_rs_used), .stg_valid(stg_valid), .stg_wen(stg_wen),
      .stg_is_load(stg_is_load), .stg_rd(stg_rd), .stg_data(stg_data),
      .stall(stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .stat_stall_cycles(stat_stall_cycles), .stat_fwd_events(stat_fwd_events)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [9:0]  rs;
      logic [1:0]  used;
      logic [2:0]  sv;
      logic [2:0]  sw;
      logic [2:0]  sl;
      logic [14:0] rd;
      logic [95:0] data;
      logic        e_stall;
      logic [1:0]  e_hit;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
   } vec_t;

   typedef struct {
      logic [1:0]  hit;
      logic [31:0] d0;
      logic [31:0] d1;
   } sb_t;

   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tally_stall = 0;
   int   tally_fwd   = 0;
   vec_t vecs[14];
   vec_t bench;

   function automatic logic [9:0] rsp(input logic [4:0] a, input logic [4:0] b);
      return {b, a};
   endfunction

   function automatic logic [14:0] rdp(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
      return {r2, r1, r0};
   endfunction

   function automatic logic [95:0] dat(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      return {d2, d1, d0};
   endfunction

   function automatic vec_t mk(input logic dv, input logic [9:0] rs, input logic [1:0] used,
                               input logic [2:0] sv, input logic [2:0] sw, input logic [2:0] sl,
                               input logic [14:0] rd, input logic [95:0] data, input logic es,
                               input logic [1:0] eh, input logic [31:0] e0, input logic [31:0] e1);
      vec_t v;
      v.dv = dv; v.rs = rs; v.used = used; v.sv = sv; v.sw = sw; v.sl = sl;
      v.rd = rd; v.data = data; v.e_stall = es; v.e_hit = eh; v.e_d0 = e0; v.e_d1 = e1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      de_valid = v.dv; de_rs = v.rs; de_rs_used = v.used;
      stg_valid = v.sv; stg_wen = v.sw; stg_is_load = v.sl;
      stg_rd = v.rd; stg_data = v.data;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; de_valid = 1'b0; de_rs = 10'd0; de_rs_used = 2'b00;
      stg_valid = 3'b000; stg_wen = 3'b000; stg_is_load = 3'b000;
      stg_rd = 15'd0; stg_data = 96'd0;
   endtask

   // Called with inputs already applied shortly after a posedge: check stall now,
   // queue the expected capture, then compare it one edge later.
   task automatic step(input string tag, input logic es, input logic [1:0] eh,
                       input logic [31:0] e0, input logic [31:0] e1);
      sb_t e;
      #1;
      chk({tag, " stall"}, {31'd0, stall}, {31'd0, es});
      e.hit = eh; e.d0 = e0; e.d1 = e1;
      sb_q.push_back(e);
      if (es) tally_stall++;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      tally_fwd += $countones(e.hit);
      chk({tag, " fwd_hit"}, {30'd0, fwd_hit}, {30'd0, e.hit});
      chk({tag, " fwd_data0"}, fwd_data[31:0], e.d0);
      chk({tag, " fwd_data1"}, fwd_data[63:32], e.d1);
   endtask

   task automatic step_vec(input string tag, input vec_t v);
      apply(v);
      step(tag, v.e_stall, v.e_hit, v.e_d0, v.e_d1);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tally_stall = 0;
      tally_fwd   = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // table: inputs and expected (stall now, fwd next cycle)
      vecs[0]  = mk(1'b1, rsp(5'd5, 5'd0), 2'b01, 3'b001, 3'b001, 3'b000, rdp(5'd5, 5'd0, 5'd0),
                    dat(32'h1234, 32'h0, 32'h0), 1'b0, 2'b01, 32'h1234, 32'h0);
      vecs[1]  = mk(1'b1, rsp(5'd0, 5'd7), 2'b10, 3'b111, 3'b111, 3'b000, rdp(5'd7, 5'd9, 5'd7),
                    dat(32'hA, 32'hC, 32'hB), 1'b0, 2'b10, 32'h0, 32'hA);
      vecs[2]  = mk(1'b1, rsp(5'd0, 5'd6), 2'b01, 3'b111, 3'b111, 3'b000, rdp(5'd0, 5'd6, 5'd0),
                    dat(32'h55, 32'h66, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0);
      vecs[3]  = mk(1'b1, rsp(5'd4, 5'd4), 2'b11, 3'b010, 3'b010, 3'b000, rdp(5'd0, 5'd4, 5'd0),
                    dat(32'h0, 32'hDEAD, 32'h0), 1'b0, 2'b11, 32'hDEAD, 32'hDEAD);
      vecs[4]  = mk(1'b1, rsp(5'd2, 5'd1), 2'b11, 3'b101, 3'b101, 3'b000, rdp(5'd1, 5'd0, 5'd2),
                    dat(32'h11, 32'h0, 32'h22), 1'b0, 2'b11, 32'h22, 32'h11);
      vecs[5]  = mk(1'b1, rsp(5'd5, 5'd0), 2'b01, 3'b001, 3'b000, 3'b000, rdp(5'd5, 5'd0, 5'd0),
                    dat(32'h5, 32'h0, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0);
      vecs[6]  = mk(1'b1, rsp(5'd5, 5'd0), 2'b01, 3'b000, 3'b001, 3'b000, rdp(5'd5, 5'd0, 5'd0),
                    dat(32'h5, 32'h0, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0);
      vecs[7]  = mk(1'b0, rsp(5'd5, 5'd0), 2'b01, 3'b001, 3'b001, 3'b000, rdp(5'd5, 5'd0, 5'd0),
                    dat(32'h5, 32'h0, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0);
      vecs[8]  = mk(1'b1, rsp(5'd8, 5'd0), 2'b01, 3'b100, 3'b100, 3'b100, rdp(5'd0, 5'd0, 5'd8),
                    dat(32'h0, 32'h0, 32'h88), 1'b0, 2'b01, 32'h88, 32'h0);
      vecs[9]  = mk(1'b1, rsp(5'd0, 5'd8), 2'b10, 3'b010, 3'b010, 3'b010, rdp(5'd0, 5'd8, 5'd0),
                    dat(32'h0, 32'h77, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0);
      vecs[10] = mk(1'b1, rsp(5'd0, 5'd8), 2'b10, 3'b011, 3'b011, 3'b010, rdp(5'd8, 5'd8, 5'd0),
                    dat(32'h99, 32'h77, 32'h0), 1'b0, 2'b10, 32'h0, 32'h99);
      vecs[11] = mk(1'b1, rsp(5'd8, 5'd0), 2'b01, 3'b110, 3'b110, 3'b010, rdp(5'd0, 5'd8, 5'd8),
                    dat(32'h0, 32'h77, 32'h66), 1'b1, 2'b00, 32'h0, 32'h0);
      vecs[12] = mk(1'b1, rsp(5'd8, 5'd8), 2'b00, 3'b010, 3'b010, 3'b010, rdp(5'd0, 5'd8, 5'd0),
                    dat(32'h0, 32'h77, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0);
      vecs[13] = mk(1'b1, rsp(5'd1, 5'd2), 2'b11, 3'b011, 3'b011, 3'b010, rdp(5'd1, 5'd2, 5'd0),
                    dat(32'h31, 32'h32, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0);

      rst = 1'b1;
      idle_inputs();
      #1;
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset fwd_hit", {30'd0, fwd_hit}, 32'd0);
      chk("reset fwd_data0", fwd_data[31:0], 32'd0);
      chk("reset fwd_data1", fwd_data[63:32], 32'd0);
      chk("reset stat_stall", stat_stall_cycles, 32'd0);
      chk("reset stat_fwd", stat_fwd_events, 32'd0);
      do_reset();

      for (int i = 0; i < 14; i++) begin
         step_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // load-use from stage 0: two stall cycles, then forward from stage 2
      step_vec("lu_c0", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b001, rdp(5'd3, 5'd0, 5'd0),
                           dat(32'hBAD0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      step_vec("lu_c1", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b010, 3'b010, 3'b010, rdp(5'd0, 5'd3, 5'd0),
                           dat(32'h0, 32'hBAD1, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      step_vec("lu_c2", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b100, 3'b100, 3'b100, rdp(5'd0, 5'd0, 5'd3),
                           dat(32'h0, 32'h0, 32'h3333), 1'b0, 2'b01, 32'h3333, 32'h0));

      // flush in the first STALL cycle clears the FSM and the capture
      step_vec("fl_c0", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b001, rdp(5'd3, 5'd0, 5'd0),
                           dat(32'hBAD0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      apply(mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b000, rdp(5'd3, 5'd0, 5'd0),
               dat(32'h77, 32'h0, 32'h0), 1'b0, 2'b00, 32'h0, 32'h0));
      flush = 1'b1;
      step("fl_c1", 1'b0, 2'b00, 32'h0, 32'h0);
      flush = 1'b0;
      step_vec("fl_c2", mk(1'b1, rsp(5'd5, 5'd0), 2'b01, 3'b001, 3'b001, 3'b000, rdp(5'd5, 5'd0, 5'd0),
                           dat(32'h4321, 32'h0, 32'h0), 1'b0, 2'b01, 32'h4321, 32'h0));

      // rst while stalling: stall and forwarding outputs drop at once
      step_vec("rs_c0", vecs[0]);
      apply(mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b001, rdp(5'd3, 5'd0, 5'd0),
               dat(32'h0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      #2;
      chk("rs_pre stall", {31'd0, stall}, 32'd1);
      chk("rs_pre fwd_hit", {30'd0, fwd_hit}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rs_async stall", {31'd0, stall}, 32'd0);
      chk("rs_async fwd_hit", {30'd0, fwd_hit}, 32'd0);
      chk("rs_async fwd_data0", fwd_data[31:0], 32'd0);
      do_reset();
      step_vec("rs_st0", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b001, rdp(5'd3, 5'd0, 5'd0),
                            dat(32'h0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      idle_inputs();
      #2;
      chk("rs_stallstate stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rs_stallstate async", {31'd0, stall}, 32'd0);
      do_reset();
      step("rs_after", 1'b0, 2'b00, 32'h0, 32'h0);

`ifdef FWD_STATS_EN
      do_reset();
      step_vec("st_lu0", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b001, 3'b001, 3'b001, rdp(5'd3, 5'd0, 5'd0),
                            dat(32'h0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      step_vec("st_lu1", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b010, 3'b010, 3'b010, rdp(5'd0, 5'd3, 5'd0),
                            dat(32'h0, 32'h0, 32'h0), 1'b1, 2'b00, 32'h0, 32'h0));
      step_vec("st_lu2", mk(1'b1, rsp(5'd3, 5'd0), 2'b01, 3'b100, 3'b100, 3'b100, rdp(5'd0, 5'd0, 5'd3),
                            dat(32'h0, 32'h0, 32'h3333), 1'b0, 2'b01, 32'h3333, 32'h0));
      step_vec("st_f1", vecs[0]);
      step_vec("st_f2", vecs[1]);
      idle_inputs();
      chk("stat_stall_cycles", stat_stall_cycles, 32'(tally_stall));
      chk("stat_fwd_events", stat_fwd_events, 32'(tally_fwd));
      chk("stat_stall_cycles abs", stat_stall_cycles, 32'd2);
      chk("stat_fwd_events abs", stat_fwd_events, 32'd3);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("stat_fwd after flush", stat_fwd_events, 32'd3);
      force dut.stat_stall_q = 32'hFFFF_FFFE;
      force dut.stat_fwd_q   = 32'hFFFF_FFFE;
      #1;
      release dut.stat_stall_q;
      release dut.stat_fwd_q;
      step_vec("sat_a", vecs[9]);
      step_vec("sat_b", vecs[9]);
      chk("stat_stall saturate", stat_stall_cycles, 32'hFFFF_FFFF);
      step_vec("sat_c", vecs[3]);
      step_vec("sat_d", vecs[0]);
      chk("stat_fwd saturate", stat_fwd_events, 32'hFFFF_FFFF);
`else
      chk("stat_stall tied", stat_stall_cycles, 32'd0);
      chk("stat_fwd tied", stat_fwd_events, 32'd0);
`endif

      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
